// File: rtl/byte_swap_pkg.sv
// Shared types and byte-permutation helpers for the byte_swap_stream endianness converter.
// Pure combinational definitions; no clocked logic and no flow control in this file.
package byte_swap_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_REV    = 2'd1,
        MODE_SWAP16 = 2'd2,
        MODE_SWAP32 = 2'd3
    } mode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    function automatic logic mode_legal(input mode_t m, input int data_width);
        logic ok;
        case (m)
            MODE_SWAP16: ok = (data_width % 16) == 0;
            MODE_SWAP32: ok = (data_width % 32) == 0;
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Source byte index feeding output byte k of an nbytes-wide beat.
    // Out-of-range lanes fall back to identity so the index is always valid.
    function automatic int src_byte(input int k, input int nbytes, input mode_t m);
        int s;
        case (m)
            MODE_REV:    s = nbytes - 1 - k;
            MODE_SWAP16: s = k ^ 1;
            MODE_SWAP32: s = k ^ 2;
            default:     s = k;
        endcase
        if (s >= nbytes || s < 0) s = k;
        return s;
    endfunction

endpackage

// File: rtl/byte_swap_skid_buffer.sv
// Main register plus one-entry skid register between a valid/ready source and sink.
// 1-cycle latency; s_rdy_o is registered (NOT skid valid) so a stall costs at most one extra beat.
module byte_swap_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         arst_n_i,
    input  logic [W-1:0] s_dat_i,
    input  logic         s_vld_i,
    output logic         s_rdy_o,
    output logic [W-1:0] m_dat_o,
    output logic         m_vld_o,
    input  logic         m_rdy_i
);

    logic         main_vld_q, main_vld_d;
    logic [W-1:0] main_dat_q, main_dat_d;
    logic         skid_vld_q, skid_vld_d;
    logic [W-1:0] skid_dat_q, skid_dat_d;
    logic         rdy_q;
    logic         in_xfer;
    logic         out_xfer;

    assign in_xfer  = s_vld_i & rdy_q;
    assign out_xfer = main_vld_q & m_rdy_i;

    always_comb begin
        main_vld_d = main_vld_q;
        main_dat_d = main_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (skid_vld_q) begin
            // Ready is low while the skid holds a beat, so only draining happens here.
            if (out_xfer) begin
                main_dat_d = skid_dat_q;
                skid_vld_d = 1'b0;
            end
        end else if (!main_vld_q || out_xfer) begin
            main_vld_d = in_xfer;
            if (in_xfer) main_dat_d = s_dat_i;
        end else if (in_xfer) begin
            skid_vld_d = 1'b1;
            skid_dat_d = s_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            main_vld_q <= 1'b0;
            main_dat_q <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            rdy_q      <= 1'b0;
        end else begin
            main_vld_q <= main_vld_d;
            main_dat_q <= main_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            rdy_q      <= ~skid_vld_d;
        end
    end

    assign s_rdy_o = rdy_q;
    assign m_dat_o = main_dat_q;
    assign m_vld_o = main_vld_q;

endmodule

// File: rtl/byte_swap_stream.sv
// Streaming byte reorder (pass / reverse / swap16 / swap32) with per-packet latched mode.
// 1-cycle latency; full throughput, backpressure absorbed by a registered skid stage.
module byte_swap_stream
    import byte_swap_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic [1:0]              mode_i,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    input  logic [DATA_WIDTH/8-1:0] s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [DATA_WIDTH-1:0]   m_data_o,
    output logic [DATA_WIDTH/8-1:0] m_keep_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic                    mode_err_o,
    output logic [CNT_WIDTH-1:0]    pkt_cnt_o
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int PW = DATA_WIDTH + NB + 1;

    state_t                 state_q, state_d;
    mode_t                  mode_q, mode_d;
    mode_t                  req_mode, cur_mode;
    logic                   req_legal;
    logic                   first_beat;
    logic                   in_xfer;
    logic                   mode_err_q, mode_err_d;
    logic [CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [DATA_WIDTH-1:0]  sw_data;
    logic [NB-1:0]          sw_keep;
    logic [PW-1:0]          out_pay;

    assign in_xfer = s_valid_i & s_ready_o;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (in_xfer) state_d = s_last_i ? IDLE : IN_PKT;
    end

    always_comb begin
        first_beat = (state_q == IDLE);
    end

    // An illegal request degrades to pass-through for the whole packet.
    assign req_mode  = mode_t'(mode_i);
    assign req_legal = mode_legal(req_mode, DATA_WIDTH);
    assign cur_mode  = first_beat ? (req_legal ? req_mode : MODE_PASS) : mode_q;

    always_comb begin
        sw_data = '0;
        sw_keep = '0;
        for (int k = 0; k < NB; k++) begin
            sw_data[8*k +: 8] = s_data_i[8*src_byte(k, NB, cur_mode) +: 8];
            sw_keep[k]        = s_keep_i[src_byte(k, NB, cur_mode)];
        end
    end

    always_comb begin
        mode_d     = mode_q;
        mode_err_d = mode_err_q;
        pkt_cnt_d  = pkt_cnt_q;
        if (in_xfer && first_beat) begin
            mode_d     = cur_mode;
            mode_err_d = mode_err_q | ~req_legal;
        end
        if (m_valid_o && m_ready_i && m_last_o) pkt_cnt_d = pkt_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            mode_q     <= MODE_PASS;
            mode_err_q <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            mode_q     <= mode_d;
            mode_err_q <= mode_err_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    byte_swap_skid_buffer #(
        .W(PW)
    ) u_skid (
        .clk_i   (clk_i),
        .arst_n_i(arst_n_i),
        .s_dat_i ({s_last_i, sw_keep, sw_data}),
        .s_vld_i (s_valid_i),
        .s_rdy_o (s_ready_o),
        .m_dat_o (out_pay),
        .m_vld_o (m_valid_o),
        .m_rdy_i (m_ready_i)
    );

    assign m_data_o   = out_pay[DATA_WIDTH-1:0];
    assign m_keep_o   = out_pay[DATA_WIDTH +: NB];
    assign m_last_o   = out_pay[PW-1];
    assign mode_err_o = mode_err_q;
    assign pkt_cnt_o  = pkt_cnt_q;

endmodule

// File: tb/tb_byte_swap_stream.sv
// Directed bench for byte_swap_stream: 32-bit and 16-bit instances share stimulus buses.
// Expected values are hand-computed constants; a random-ready stream checks ordering.
module tb_byte_swap_stream;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] s_data = '0;
    logic [3:0]  s_keep = '0;
    logic        s_last = 1'b0;
    logic        s_valid32 = 1'b0;
    logic        s_valid16 = 1'b0;
    logic        m_ready = 1'b1;

    logic        s_ready32, m_last32, m_valid32, err32;
    logic [31:0] m_data32;
    logic [3:0]  m_keep32;
    logic [15:0] cnt32;

    logic        s_ready16, m_last16, m_valid16, err16;
    logic [15:0] m_data16;
    logic [1:0]  m_keep16;
    logic [15:0] cnt16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    byte_swap_stream #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut32 (
        .clk_i(clk), .arst_n_i(arst_n), .mode_i(mode),
        .s_data_i(s_data), .s_keep_i(s_keep), .s_last_i(s_last),
        .s_valid_i(s_valid32), .s_ready_o(s_ready32),
        .m_data_o(m_data32), .m_keep_o(m_keep32), .m_last_o(m_last32),
        .m_valid_o(m_valid32), .m_ready_i(m_ready),
        .mode_err_o(err32), .pkt_cnt_o(cnt32)
    );

    byte_swap_stream #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut16 (
        .clk_i(clk), .arst_n_i(arst_n), .mode_i(mode),
        .s_data_i(s_data[15:0]), .s_keep_i(s_keep[1:0]), .s_last_i(s_last),
        .s_valid_i(s_valid16), .s_ready_o(s_ready16),
        .m_data_o(m_data16), .m_keep_o(m_keep16), .m_last_o(m_last16),
        .m_valid_o(m_valid16), .m_ready_i(m_ready),
        .mode_err_o(err16), .pkt_cnt_o(cnt16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called away from a clock edge; returns at posedge+1 after the beat is accepted.
    task automatic push(input int sel, input logic [31:0] d, input logic [3:0] k,
                        input logic l, input logic [1:0] m);
        logic rdy;
        int   n;
        n = 0;
        s_data = d;
        s_keep = k;
        s_last = l;
        mode   = m;
        if (sel == 16) s_valid16 = 1'b1;
        else           s_valid32 = 1'b1;
        forever begin
            rdy = (sel == 16) ? s_ready16 : s_ready32;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 200) begin
                check("push_timeout", 64'd1, 64'd0);
                break;
            end
        end
        s_valid16 = 1'b0;
        s_valid32 = 1'b0;
    endtask

    // Waits for an output beat, compares it and lets it transfer (m_ready assumed high).
    task automatic expect_out(input int sel, input string tag, input logic [31:0] d,
                              input logic [3:0] k, input logic l);
        logic v;
        int   n;
        n = 0;
        do begin
            @(negedge clk);
            v = (sel == 16) ? m_valid16 : m_valid32;
            n++;
        end while (!v && n < 50);
        check({tag, "_vld"}, {63'd0, v}, 64'd1);
        if (sel == 16) begin
            check({tag, "_dat"}, {48'd0, m_data16}, {48'd0, d[15:0]});
            check({tag, "_keep"}, {62'd0, m_keep16}, {62'd0, k[1:0]});
            check({tag, "_last"}, {63'd0, m_last16}, {63'd0, l});
        end else begin
            check({tag, "_dat"}, {32'd0, m_data32}, {32'd0, d});
            check({tag, "_keep"}, {60'd0, m_keep32}, {60'd0, k});
            check({tag, "_last"}, {63'd0, m_last32}, {63'd0, l});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", {63'd0, s_ready32}, 64'd0);
        check("rst_m_valid", {63'd0, m_valid32}, 64'd0);
        check("rst_m_data", {32'd0, m_data32}, 64'd0);
        check("rst_m_keep", {60'd0, m_keep32}, 64'd0);
        check("rst_m_last", {63'd0, m_last32}, 64'd0);
        check("rst_err", {63'd0, err32}, 64'd0);
        check("rst_cnt", {48'd0, cnt32}, 64'd0);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_s_ready", {63'd0, s_ready32}, 64'd1);

        // Single-beat packets in each mode.
        push(32, 32'h11223344, 4'b0011, 1'b1, 2'd1);
        expect_out(32, "rev", 32'h44332211, 4'b1100, 1'b1);
        check("cnt_after_rev", {48'd0, cnt32}, 64'd1);
        push(32, 32'h11223344, 4'b0011, 1'b1, 2'd2);
        expect_out(32, "swap16", 32'h22114433, 4'b0011, 1'b1);
        push(32, 32'h11223344, 4'b0011, 1'b1, 2'd3);
        expect_out(32, "swap32", 32'h33441122, 4'b1100, 1'b1);
        push(32, 32'h11223344, 4'b0011, 1'b1, 2'd0);
        expect_out(32, "pass", 32'h11223344, 4'b0011, 1'b1);
        check("cnt_after_4", {48'd0, cnt32}, 64'd4);

        // Mode changes mid-packet are ignored until the next packet.
        push(32, 32'h01020304, 4'b1111, 1'b0, 2'd1);
        expect_out(32, "mp_b0", 32'h04030201, 4'b1111, 1'b0);
        push(32, 32'hA1B2C3D4, 4'b0001, 1'b0, 2'd2);
        expect_out(32, "mp_b1", 32'hD4C3B2A1, 4'b1000, 1'b0);
        push(32, 32'h11223344, 4'b1111, 1'b1, 2'd2);
        expect_out(32, "mp_b2", 32'h44332211, 4'b1111, 1'b1);
        push(32, 32'h11223344, 4'b1111, 1'b1, 2'd2);
        expect_out(32, "next_pkt", 32'h22114433, 4'b1111, 1'b1);
        check("cnt_after_mp", {48'd0, cnt32}, 64'd6);
        check("err32_clear", {63'd0, err32}, 64'd0);

        // 16-bit instance: swap32 is illegal and degrades to pass.
        push(16, 32'h0000AABB, 4'b0001, 1'b1, 2'd3);
        expect_out(16, "w16_illegal", 32'h0000AABB, 4'b0001, 1'b1);
        check("w16_err_set", {63'd0, err16}, 64'd1);
        push(16, 32'h0000AABB, 4'b0001, 1'b1, 2'd1);
        expect_out(16, "w16_rev", 32'h0000BBAA, 4'b0010, 1'b1);
        push(16, 32'h00001234, 4'b0001, 1'b1, 2'd2);
        expect_out(16, "w16_swap16", 32'h00003412, 4'b0010, 1'b1);
        check("w16_err_sticky", {63'd0, err16}, 64'd1);
        check("w16_cnt", {48'd0, cnt16}, 64'd3);

        // Random backpressure stream.
        fork
            begin
                for (int i = 0; i < 100; i++)
                    push(32, 32'h10000000 + i, 4'hF, (i % 4) == 3, 2'd0);
            end
            begin
                int   got;
                int   cyc;
                int   viol_rdy;
                int   viol_hold;
                logic prev_mr;
                logic hold;
                logic [31:0] hold_dat;
                got = 0; cyc = 0; viol_rdy = 0; viol_hold = 0;
                prev_mr = 1'b1; hold = 1'b0; hold_dat = '0;
                while (got < 100 && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                    if (prev_mr && !s_ready32) viol_rdy++;
                    if (hold && (!m_valid32 || m_data32 !== hold_dat)) viol_hold++;
                    if (m_valid32 && m_ready) begin
                        check("stream_dat", {32'd0, m_data32}, {32'd0, 32'h10000000 + got});
                        got++;
                        hold = 1'b0;
                    end else begin
                        hold     = m_valid32;
                        hold_dat = m_data32;
                    end
                    prev_mr = m_ready;
                    @(posedge clk);
                    #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
                check("stream_beats", 64'(got), 64'd100);
                check("stream_ready_recovery", 64'(viol_rdy), 64'd0);
                check("stream_hold_stable", 64'(viol_hold), 64'd0);
            end
        join
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("stream_no_dup", {63'd0, m_valid32}, 64'd0);
        check("stream_pkt_cnt", {48'd0, cnt32}, 64'd31);

        // Reset mid-packet with the skid full.
        m_ready = 1'b0;
        push(32, 32'hAAAA0001, 4'hF, 1'b0, 2'd1);
        push(32, 32'hAAAA0002, 4'hF, 1'b0, 2'd2);
        check("skid_full_s_ready", {63'd0, s_ready32}, 64'd0);
        check("skid_full_m_valid", {63'd0, m_valid32}, 64'd1);
        arst_n = 1'b0;
        #1;
        check("midrst_m_valid", {63'd0, m_valid32}, 64'd0);
        check("midrst_cnt", {48'd0, cnt32}, 64'd0);
        check("midrst_err16", {63'd0, err16}, 64'd0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        push(32, 32'h11223344, 4'b0011, 1'b1, 2'd3);
        expect_out(32, "fresh_mode", 32'h33441122, 4'b1100, 1'b1);
        check("fresh_cnt", {48'd0, cnt32}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
